// File: rtl/sd_pkg.sv
// Shared definitions for the sigma-delta modulator/decimator family:
// accumulator width rule and the bitstream-to-signed mapping.
package sd_pkg;

    localparam logic signed [1:0] SD_POS = 2'sb01;
    localparam logic signed [1:0] SD_NEG = 2'sb11;

    // Bit growth of an ORDER-stage CIC decimating by 2^decim_log2, plus sign and input headroom.
    function automatic int acc_width(input int order, input int decim_log2);
        return order * decim_log2 + 2;
    endfunction

endpackage

// File: rtl/sd_cic_integrator.sv
// One CIC integrator stage: a wrapping two's-complement accumulator with enable.
module sd_cic_integrator #(
    parameter int ACC_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [ACC_W-1:0] din,
    output logic [ACC_W-1:0] acc
);

    logic [ACC_W-1:0] acc_q, acc_d;

    // Modulo 2^ACC_W wrap is intentional; the comb differences cancel it.
    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d = acc_q + din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/sd_cic_decimator.sv
// CIC decimator turning a 1-bit sigma-delta stream into signed words,
// one word per 2^DECIM_LOG2 accepted bits.
module sd_cic_decimator
    import sd_pkg::*;
#(
    parameter int ORDER      = 2,
    parameter int DECIM_LOG2 = 6,
    parameter int OUT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bs_in,
    input  logic             bs_valid,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid
);

    localparam int ACC_W = acc_width(ORDER, DECIM_LOG2);
    localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;

    logic signed [1:0]             x_map;
    logic [ORDER:0][ACC_W-1:0]     integ;
    logic [ORDER-1:0][ACC_W-1:0]   dly_q, dly_d;
    logic [ACC_W-1:0]              comb_acc;
    logic [DECIM_LOG2-1:0]         cnt_q, cnt_d;
    logic                          tick_q, tick_d;
    logic [OUT_W-1:0]              dout_q, dout_d;
    logic                          dout_valid_q, dout_valid_d;

    assign x_map    = bs_in ? SD_POS : SD_NEG;
    assign integ[0] = ACC_W'(x_map);

    for (genvar k = 0; k < ORDER; k++) begin : g_integ
        sd_cic_integrator #(
            .ACC_W (ACC_W)
        ) u_integ (
            .clk   (clk),
            .reset (reset),
            .en    (bs_valid),
            .din   (integ[k]),
            .acc   (integ[k+1])
        );
    end

    // Comb chain reads the registered last integrator, so a sample accepted
    // in the tick cycle lands in the next frame rather than this one.
    always_comb begin
        dly_d    = dly_q;
        comb_acc = integ[ORDER];
        for (int k = 0; k < ORDER; k++) begin
            if (tick_q) begin
                dly_d[k] = comb_acc;
            end
            comb_acc = comb_acc - dly_q[k];
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        tick_d       = 1'b0;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        if (bs_valid) begin
            cnt_d  = cnt_q + DECIM_LOG2'(1);
            tick_d = (cnt_q == CNT_LAST);
        end
        if (tick_q) begin
            dout_d       = OUT_W'($signed(comb_acc));
            dout_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dly_q        <= '0;
            cnt_q        <= '0;
            tick_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dly_q        <= dly_d;
            cnt_q        <= cnt_d;
            tick_q       <= tick_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_sd_cic_decimator.sv
// Bench for sd_cic_decimator: table of stimulus scenarios plus a latency
// sequence, checked against a triangular-window reference of the 2nd-order CIC.
module tb_sd_cic_decimator;

    localparam int DECIM = 64;
    localparam int NOCHK = 32'h7fff_ffff;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bs_in = 1'b0;
    logic        bs_valid = 1'b0;
    logic [15:0] dout;
    logic        dout_valid;

    int vectors = 0;
    int miscompares = 0;
    int edge_n = 0;

    typedef struct {
        int val;
        int due;
    } pend_t;

    typedef struct {
        int pat;        // 0 ones, 1 zeros, 2 alternating, 3 random
        int vmode;      // 0 always valid, 1 every other cycle, 2 random gaps
        int frames;
        int rst_after;  // accepted bits before a mid-frame reset, 0 = none
        int exp_first;
        int exp_later;
        int later_from;
        int spacing;    // cycles between strobes, 0 = unchecked
    } vec_t;

    int    hist[$];
    pend_t exp_q[$];
    int    got_val[$];
    int    got_edge[$];

    sd_cic_decimator dut (
        .clk        (clk),
        .reset      (reset),
        .bs_in      (bs_in),
        .bs_valid   (bs_valid),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    task automatic note(input string name, input logic signed [31:0] got,
                        input logic signed [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            if (miscompares <= 30)
                $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, expv, edge_n);
        end
    endtask

    // For order 2 the output equals the input convolved with a triangle of
    // length 2*DECIM (weights 0,1,..,63,64,63,..,1) ending at the newest bit.
    function automatic int cic_expected();
        int n = hist.size();
        int s = 0;
        for (int d = 0; d < 2 * DECIM && d < n; d++) begin
            int w = (d < DECIM) ? d : 2 * DECIM - d;
            s += w * hist[n - 1 - d];
        end
        return s;
    endfunction

    task automatic check_edge();
        logic due;
        due = (exp_q.size() > 0) && (exp_q[0].due == edge_n);
        note("strobe", {31'd0, dout_valid}, {31'd0, due});
        if (dout_valid === 1'b1) begin
            got_val.push_back(int'($signed(dout)));
            got_edge.push_back(edge_n);
        end
        if (due) begin
            pend_t e = exp_q.pop_front();
            if (dout_valid === 1'b1)
                note("dout_model", $signed(dout), e.val);
        end
    endtask

    task automatic step(input logic b, input logic v, input logic r);
        bs_in    = b;
        bs_valid = v;
        reset    = r;
        @(posedge clk);
        edge_n++;
        if (r) begin
            hist.delete();
            exp_q.delete();
        end else if (v) begin
            hist.push_back(b ? 1 : -1);
            if (hist.size() % DECIM == 0) begin
                pend_t p;
                p.val = cic_expected();
                p.due = edge_n + 1;
                exp_q.push_back(p);
            end
        end
        #1;
        check_edge();
    endtask

    function automatic logic pat_bit(input int pat, input int idx);
        case (pat)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (idx % 2) == 1;
            default: return 1'($urandom);
        endcase
    endfunction

    task automatic run_row(input int row, input vec_t v);
        int acc = 0;
        int cyc = 0;
        int budget;
        bit rst_done = 0;
        logic val;
        logic b;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        got_val.delete();
        got_edge.delete();
        budget = v.frames * DECIM * 8 + 400;
        while (got_val.size() < v.frames && cyc < budget) begin
            if (v.rst_after > 0 && !rst_done && acc == v.rst_after) begin
                step(1'b1, 1'b1, 1'b1);
                acc      = 0;
                rst_done = 1;
            end else begin
                case (v.vmode)
                    0:       val = 1'b1;
                    1:       val = (cyc % 2) == 0;
                    default: val = ($urandom_range(0, 3) != 0);
                endcase
                b = val ? pat_bit(v.pat, acc + 1) : 1'($urandom);
                step(b, val, 1'b0);
                if (val) acc++;
            end
            cyc++;
        end
        note($sformatf("row%0d_outputs", row), got_val.size(), v.frames);
        for (int i = 0; i < got_val.size(); i++) begin
            if (i == 0 && v.exp_first != NOCHK)
                note($sformatf("row%0d_first", row), got_val[i], v.exp_first);
            if (i >= v.later_from && v.exp_later != NOCHK)
                note($sformatf("row%0d_out%0d", row, i), got_val[i], v.exp_later);
            if (i >= 1 && v.spacing > 0)
                note($sformatf("row%0d_spacing%0d", row, i), got_edge[i] - got_edge[i-1], v.spacing);
        end
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{0, 0, 4,   0,  2016,  4096,  1, 64};
        tbl[1] = '{1, 0, 4,   0, -2016, -4096,  1, 64};
        tbl[2] = '{2, 0, 6,   0, NOCHK,     0,  2, 64};
        tbl[3] = '{0, 1, 4,   0,  2016,  4096,  1, 128};
        tbl[4] = '{0, 0, 3,  40,  2016,  4096,  1, 64};
        tbl[5] = '{0, 0, 300, 0,  2016,  4096,  1, 64};
        tbl[6] = '{3, 2, 20,  0, NOCHK, NOCHK,  0, 0};
        tbl[7] = '{0, 2, 5,   0,  2016,  4096,  1, 0};

        // Reset state, with bs_valid held high to show reset dominates.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        note("reset_dout", $signed(dout), 0);
        note("reset_valid", {31'd0, dout_valid}, 0);

        // Latency: 64th accepted bit at edge E, strobe visible only after E+1.
        for (int i = 0; i < DECIM - 1; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        note("lat_after_E", {31'd0, dout_valid}, 0);
        step(1'b0, 1'b0, 1'b0);
        note("lat_after_E1", {31'd0, dout_valid}, 1);
        note("lat_value", $signed(dout), 2016);
        step(1'b0, 1'b0, 1'b0);
        note("lat_after_E2", {31'd0, dout_valid}, 0);
        note("lat_hold", $signed(dout), 2016);

        for (int r = 0; r < 8; r++) run_row(r, tbl[r]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sd_cic_decimator.md
Name: sd_cic_decimator

Overview:
- Receive-side counterpart of the team's sigma-delta modulators: takes a 1-bit sigma-delta bitstream and reconstructs a multi-bit signed sample stream.
- Uses an ORDER-stage CIC (cascaded integrator-comb) filter decimating by 2^DECIM_LOG2.
- Sits downstream of any modulator bitstream output (bit 1 maps to +1, bit 0 maps to -1).
- Emits one signed word per DECIM accepted input bits, with a single-cycle valid strobe.

Parameters:
- ORDER, 2, number of integrator stages and number of comb stages (legal range 1..3).
- DECIM_LOG2, 6, log2 of the decimation ratio; DECIM = 2^DECIM_LOG2 = 64.
- OUT_W, 16, width of dout; must be >= ACC_W.
- Derived (not overridable): ACC_W = ORDER*DECIM_LOG2 + 2, which is 14 at defaults.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- bs_in  input  1  bitstream sample: 1 means +1, 0 means -1.
- bs_valid  input  1  bs_in is accepted at posedge only when this is 1.
- dout  output  OUT_W  decimated signed sample, sign-extended from ACC_W.
- dout_valid  output  1  one-cycle strobe; dout is valid only while this is 1.

Behaviour:
- Reset (synchronous, active-high): all integrators, comb delays, decim counter, tick register, dout and dout_valid clear to 0. Reset dominates bs_valid in the same cycle.
- Reset mid-frame: the partial frame is discarded; the next frame starts counting from zero.
- Input mapping: x = bs_in ? +1 : -1, sign-extended to ACC_W.
- Integrators (accepted cycle only):
  - i1 <= i1 + x.
  - i_k <= i_k + i_(k-1), using the pre-edge (registered) value of i_(k-1).
  - All hold when bs_valid = 0.
- Integrator arithmetic is modulo 2^ACC_W. Two's-complement wrap is required for CIC correctness; no saturation and no capped adders.
- Decim counter cnt (DECIM_LOG2 bits):
  - Increments on each accepted sample.
  - Wraps from DECIM-1 to 0.
  - An accepted sample with cnt == DECIM-1 sets tick <= 1 for exactly one cycle; otherwise tick <= 0.
- Comb section (evaluated in the cycle tick = 1, operating on registered i_ORDER):
  - c0 = i_ORDER.
  - c_k = c_(k-1) - d_k, with d_k <= c_(k-1); all modulo 2^ACC_W.
  - Delays d_k update only when tick = 1.
- Output registers, written at the edge where tick = 1:
  - dout <= sign-extend(c_ORDER).
  - dout_valid <= 1.
  - Otherwise dout_valid <= 0 and dout holds its last value.
- Latency: if the edge accepting the DECIM-th bit is edge E, tick is high after E and dout_valid is high for the one cycle after edge E+1.
- bs_valid during tick cycle: new accepted samples update the integrators normally. The comb has already sampled pre-edge i_ORDER, so no sample is lost or double-counted.
- bs_valid gaps: they stretch the frame in time but do not change the result. Frame boundaries are counted in accepted samples, not cycles.
- Gain: the steady-state output for constant input is ±DECIM^ORDER (±4096 at defaults). The first ORDER-1 outputs after reset are transient.
- No back-pressure: the consumer must take dout on the dout_valid strobe.

Decomposition:
- Shared package (sd_pkg): ACC_W derivation function; the bit-to-±1 mapping constants (SD_POS = +1, SD_NEG = -1) shared with the modulators.
- One natural sub-module: sd_cic_integrator, a single ACC_W wrapping accumulator with an enable. It is instantiated ORDER times via generate.
- The comb stages and counter stay inline.

Test Plan:
- All-ones, bs_valid = 1 continuously from reset release (defaults):
  - 1st dout_valid: dout = 2016.
  - 2nd and all later: dout = 4096.
  - Strobes exactly 64 cycles apart.
- All-zeros, same setup: 1st dout = -2016, then -4096 thereafter (0xF000 in 16 bits).
- Alternating 1,0,1,0...: after the 2nd output, every dout = 0.
- Latency check: the 64th accepted bit at edge E produces dout_valid high for exactly the one cycle following edge E+1.
- All-ones with bs_valid = 1 every other cycle: same values as the all-ones case (2016, then 4096), with strobes 128 cycles apart.
- Reset held 1 cycle after 40 accepted bits, then all-ones resumes:
  - No dout_valid within the next 64 accepted bits except at the 64th.
  - That first output is 2016 (full clear verified).
- Long run (≥300 frames) of all-ones: output stays 4096 throughout integrator wrap.
